// File: rtl/sd4_partial_product_generator_if.sv
// ---------------------------------------------------------------------------
// sd4_partial_product_generator_if
//   Operand/result bundle for the SD4 partial-product generator.
//
//   Signals
//     in_valid   1  image/weight valid this cycle
//     image      8  unsigned activation, 0..255
//     weight     4  two's-complement weight, -8..7
//     out_valid  1  signed_pp/exp valid
//     signed_pp  5  two's-complement mantissa, -16..15
//     exp        5  unsigned right-shift exponent, 0..7 (exp[4:3] always 0)
//
//   Modports
//     master  operand producer (drives in_valid/image/weight, sees results)
//     slave   the generator itself
// ---------------------------------------------------------------------------
interface sd4_partial_product_generator_if;
  logic              in_valid;
  logic [7:0]        image;
  logic [3:0]        weight;
  logic              out_valid;
  logic signed [4:0] signed_pp;
  logic [4:0]        exp;

  modport master (
    output in_valid,
    output image,
    output weight,
    input  out_valid,
    input  signed_pp,
    input  exp
  );

  modport slave (
    input  in_valid,
    input  image,
    input  weight,
    output out_valid,
    output signed_pp,
    output exp
  );
endinterface

// File: rtl/sd4_partial_product_generator.sv
// ---------------------------------------------------------------------------
// sd4_partial_product_generator
//   Front end of the SD4 MAC datapath. Multiplies an unsigned 8-bit image by
//   a signed 4-bit weight using radix-4 signed-digit (Booth) recoding of the
//   weight, then emits the product in compact form:
//     product ~= signed_pp * 2^exp
//   The downstream accumulator aligns terms by exp before summing.
//
//   Ports
//     clk   in   rising-edge clock, single domain
//     rst   in   synchronous, active-high reset (clears out_valid/signed_pp/exp)
//     bus   slave modport of sd4_partial_product_generator_if
//
//   Timing: one register stage, one operand pair accepted every cycle.
//   When in_valid is low, out_valid drops next cycle and signed_pp/exp hold.
//
//   Configuration macro: SD4_PP_ROUND_EN
//     undefined - normalisation truncates (arithmetic shift, floor)
//     defined   - normalisation rounds half up; a rounding carry that leaves
//                 the mantissa range pushes the result to the next exponent
// ---------------------------------------------------------------------------
module sd4_partial_product_generator (
  input  logic                           clk,
  input  logic                           rst,
  sd4_partial_product_generator_if.slave bus
);

  localparam int NUM_DIGITS = 2;
  localparam int NUM_EXPS   = 8;

  // -------------------------------------------------------------------------
  // Booth recoding
  // Weight extended with the implicit w[-1]=0 so every digit sees a uniform
  // three-bit window {w[2i+1], w[2i], w[2i-1]}.
  // -------------------------------------------------------------------------
  logic [4:0] weight_ext;
  assign weight_ext = {bus.weight, 1'b0};

  logic [2:0]        booth_grp  [NUM_DIGITS];
  logic              digit_neg  [NUM_DIGITS];
  logic              digit_one  [NUM_DIGITS];
  logic              digit_two  [NUM_DIGITS];
  logic [8:0]        digit_mag  [NUM_DIGITS];
  logic signed [9:0] digit_pp   [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign booth_grp[gi] = weight_ext[2*gi+2 -: 3];

      // d = -2*b2 + b1 + b0. |d|==1 when b1!=b0; |d|==2 for 100/011.
      // Window 111 gives neg with zero magnitude, which negates to 0.
      assign digit_neg[gi] = booth_grp[gi][2];
      assign digit_one[gi] = booth_grp[gi][1] ^ booth_grp[gi][0];
      assign digit_two[gi] = (booth_grp[gi] == 3'b100) ||
                             (booth_grp[gi] == 3'b011);

      always_comb begin
        digit_mag[gi] = 9'd0;
        if (digit_two[gi]) begin
          digit_mag[gi] = {bus.image, 1'b0};
        end else if (digit_one[gi]) begin
          digit_mag[gi] = {1'b0, bus.image};
        end
      end

      assign digit_pp[gi] = digit_neg[gi] ? -$signed({1'b0, digit_mag[gi]})
                                          :  $signed({1'b0, digit_mag[gi]});
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Product = PP0 + 4*PP1. |PP1| <= 510 so {PP1,2'b00} stays within 12 bits;
  // the full result spans -2040..1785.
  // -------------------------------------------------------------------------
  logic signed [11:0] product;
  assign product = $signed({{2{digit_pp[0][9]}}, digit_pp[0]}) +
                   $signed({digit_pp[1], 2'b00});

  // -------------------------------------------------------------------------
  // Normalisation: evaluate every candidate exponent in parallel, then keep
  // the smallest one whose shifted value fits the 5-bit mantissa.
  // -------------------------------------------------------------------------
  logic signed [11:0] cand_src  [NUM_EXPS];
  logic signed [11:0] cand_val  [NUM_EXPS];
  logic               cand_fits [NUM_EXPS];

  generate
    for (genvar gi = 0; gi < NUM_EXPS; gi++) begin : g_exp
`ifdef SD4_PP_ROUND_EN
      // Add half an LSB of the target exponent before shifting. Headroom:
      // 1785 + 64 still fits a signed 12-bit value.
      if (gi == 0) begin : g_no_half
        assign cand_src[gi] = product;
      end else begin : g_half
        localparam logic signed [11:0] HALF_LSB = 12'sd1 <<< (gi - 1);
        assign cand_src[gi] = product + HALF_LSB;
      end
`else
      assign cand_src[gi] = product;
`endif
      assign cand_val[gi]  = cand_src[gi] >>> gi;
      // Fits in [-16,15] when bits 11..4 are all copies of the sign.
      assign cand_fits[gi] = (&cand_val[gi][11:4]) | ~(|cand_val[gi][11:4]);
    end
  endgenerate

  logic [2:0]        sel_exp;
  logic signed [4:0] sel_pp;

  // Scan from the largest exponent down so the smallest fitting one wins.
  // Exponent 7 always fits for legal operands, so it is also the default.
  always_comb begin
    sel_exp = 3'd7;
    sel_pp  = cand_val[NUM_EXPS-1][4:0];
    for (int k = NUM_EXPS - 1; k >= 0; k--) begin
      if (cand_fits[k]) begin
        sel_exp = 3'(k);
        sel_pp  = cand_val[k][4:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  logic              out_valid_reg;
  logic signed [4:0] signed_pp_reg;
  logic [2:0]        exp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      signed_pp_reg <= '0;
      exp_reg       <= '0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        signed_pp_reg <= sel_pp;
        exp_reg       <= sel_exp;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.signed_pp = signed_pp_reg;
  assign bus.exp       = {2'b00, exp_reg};

endmodule

// File: tb/tb_sd4_partial_product_generator.sv
// ---------------------------------------------------------------------------
// tb_sd4_partial_product_generator
//   Directed cases with known answers, an exhaustive image x weight sweep and
//   a randomized stream with gaps and resets, all scored against a reference
//   model that multiplies with integer arithmetic and searches for the
//   smallest fitting exponent. Build with SD4_PP_ROUND_EN to score the
//   rounding variant.
// ---------------------------------------------------------------------------
module tb_sd4_partial_product_generator;

`ifdef SD4_PP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd4_partial_product_generator_if dut_bus ();

  sd4_partial_product_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_bus)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Expected registered outputs after the most recent clock edge.
  int m_valid = 0;
  int m_pp    = 0;
  int m_exp   = 0;

  task automatic check_value(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s txn=%0d got=%0d want=%0d", tag, txn, observed, expected);
    end
  endtask

  // Smallest exponent e in 0..7 whose (rounded) scaled product fits [-16,15].
  function automatic void ref_norm(input int p, output int pp, output int e);
    bit found;
    int r;
    found = 1'b0;
    pp    = 0;
    e     = 0;
    for (int k = 0; k < 8; k++) begin
      if (RND && k > 0) r = (p + (1 << (k - 1))) >>> k;
      else              r = p >>> k;
      if (!found && r >= -16 && r <= 15) begin
        found = 1'b1;
        pp    = r;
        e     = k;
      end
    end
  endfunction

  // Drive one cycle (called at a falling edge), advance the model, then at
  // the next falling edge compare the DUT with the model.
  task automatic cycle(input logic r, input logic v, input int img, input int w);
    int p;
    int pp;
    int e;
    rst              = r;
    dut_bus.in_valid = v;
    dut_bus.image    = img[7:0];
    dut_bus.weight   = w[3:0];
    if (r) begin
      m_valid = 0;
      m_pp    = 0;
      m_exp   = 0;
    end else if (v) begin
      p = img * w;
      ref_norm(p, pp, e);
      m_valid = 1;
      m_pp    = pp;
      m_exp   = e;
    end else begin
      m_valid = 0;
    end
    @(negedge clk);
    txn++;
    $display("txn %0d rst=%0d in_valid=%0d image=%0d weight=%0d -> out_valid=%0d signed_pp=%0d exp=%0d",
             txn, r, v, img, w, dut_bus.out_valid, $signed(dut_bus.signed_pp), dut_bus.exp);
    check_value("out_valid", int'(dut_bus.out_valid), m_valid);
    check_value("signed_pp", int'($signed(dut_bus.signed_pp)), m_pp);
    check_value("exp", int'(dut_bus.exp), m_exp);
  endtask

  // Known-answer check of the current outputs.
  task automatic expect_out(input string tag, input int valid, input int pp, input int e);
    check_value({tag, "_valid"}, int'(dut_bus.out_valid), valid);
    check_value({tag, "_pp"}, int'($signed(dut_bus.signed_pp)), pp);
    check_value({tag, "_exp"}, int'(dut_bus.exp), e);
  endtask

  initial begin
    rst              = 1'b1;
    dut_bus.in_valid = 1'b0;
    dut_bus.image    = '0;
    dut_bus.weight   = '0;

    // Reset wins over a valid operand.
    cycle(1'b1, 1'b1, 255, 7);
    expect_out("reset0", 0, 0, 0);
    cycle(1'b1, 1'b1, 255, 7);
    expect_out("reset1", 0, 0, 0);

    // Small products, back to back.
    cycle(1'b0, 1'b1, 7, 1);
    expect_out("i7w1", 1, 7, 0);
    cycle(1'b0, 1'b1, 7, 3);
    expect_out("i7w3", 1, RND ? 11 : 10, 1);
    cycle(1'b0, 1'b1, 7, -3);
    expect_out("i7wm3", 1, RND ? -10 : -11, 1);
    cycle(1'b0, 1'b1, 2, -8);
    expect_out("i2wm8", 1, -16, 0);

    // Extremes.
    cycle(1'b0, 1'b1, 255, -8);
    expect_out("i255wm8", 1, -16, 7);
    cycle(1'b0, 1'b1, 255, 7);
    expect_out("i255w7", 1, RND ? 14 : 13, 7);

    // Zero and rounding carry into the next exponent.
    cycle(1'b0, 1'b1, 0, -5);
    expect_out("i0wm5", 1, 0, 0);
    cycle(1'b0, 1'b1, 31, 1);
    expect_out("i31w1", 1, RND ? 8 : 15, RND ? 2 : 1);

    // Idle cycles: valid drops, data holds even though the inputs change.
    cycle(1'b0, 1'b0, 99, 2);
    expect_out("hold0", 0, RND ? 8 : 15, RND ? 2 : 1);
    cycle(1'b0, 1'b0, 200, -7);
    expect_out("hold1", 0, RND ? 8 : 15, RND ? 2 : 1);

    // Reset in the middle of a stream, then resume.
    cycle(1'b0, 1'b1, 255, 7);
    cycle(1'b1, 1'b1, 3, 3);
    expect_out("midrst", 0, 0, 0);
    cycle(1'b0, 1'b1, 3, 3);
    expect_out("resume", 1, 9, 0);

    // Exhaustive sweep, one operand pair per cycle.
    for (int img = 0; img < 256; img++) begin
      for (int w = -8; w < 8; w++) begin
        cycle(1'b0, 1'b1, img, w);
      end
    end

    // Randomized stream with gaps and occasional resets.
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)) - 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
